// File: rtl/gray_conv_arbiter_pkg.sv
// Shared definitions for the Gray conversion arbiter and later Gray blocks.
//   IDLE/CONV/HOLD : arbiter FSM state encoding
//   gray_encode    : binary-to-Gray on a 32-bit container. Callers zero-extend
//                    their operand and truncate the result back to their width.
//                    Zero-extension keeps the Gray MSB equal to the binary MSB.
package gray_conv_arbiter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  function automatic logic [31:0] gray_encode(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_gray_enc.sv
// Combinational W-bit binary-to-Gray encoder.
//   bin  : binary operand
//   gray : Gray code of bin (gray[W-1] = bin[W-1], gray[i] = bin[i]^bin[i+1])
module gray_enc
  import gray_conv_arbiter_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = W'(gray_encode(32'(bin)));

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter in front of one shared Gray encoder.
// Each requester uses a 4-phase req/ack handshake.
//   clk, rst       : clock; asynchronous active-low reset
//   req0/din0      : requester 0 request and binary operand
//   req1/din1      : requester 1 request and binary operand
//   ack0/ack1      : result ready for the owning requester (at most one high)
//   dout/dout_vld  : registered Gray result and its valid flag
//   busy           : FSM outside IDLE
//   owner          : current or last granted requester (resets to 1 so that
//                    requester 0 wins the first tie)
// Every output comes straight from a flop.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] din0,
  input  logic         req1,
  input  logic [W-1:0] din1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  output logic         busy,
  output logic         owner
);

  logic [1:0]   state;
  logic [W-1:0] operand;
  logic [W-1:0] gray;
  logic         req_own;
  logic         grant;

  // The encoder only sees the operand latched at grant, so din changes
  // after the grant cannot reach dout.
  gray_enc #(.W(W)) u_enc (
    .bin  (operand),
    .gray (gray)
  );

  assign req_own = owner ? req1 : req0;
  // A lone request wins outright; on a tie the last owner yields.
  assign grant   = (req0 & req1) ? ~owner : req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b1;
      operand  <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0 | req1) begin
          state   <= CONV;
          busy    <= 1'b1;
          owner   <= grant;
          operand <= grant ? din1 : din0;
        end
        CONV: if (req_own) begin
          state    <= HOLD;
          dout     <= gray;
          dout_vld <= 1'b1;
          ack0     <= ~owner;
          ack1     <= owner;
        end else begin
          // The owner aborted before the result was ready. The previous
          // dout and dout_vld are left untouched.
          state <= IDLE;
          busy  <= 1'b0;
        end
        HOLD: if (!req_own) begin
          // dout keeps its last value. Only the valid flag drops.
          state    <= IDLE;
          busy     <= 1'b0;
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          dout_vld <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          dout_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter (W=3).
// Each table row gives the inputs driven before one rising edge and the
// outputs expected just after that edge. Hand-written sequences follow the
// table: round-robin alternation and ack mutual exclusion.
module tb_gray_conv_arbiter;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         req0;
  logic         req1;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         ack0;
  logic         ack1;
  logic         dout_vld;
  logic         busy;
  logic         owner;
  logic [W-1:0] dout;

  gray_conv_arbiter #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .din0     (din0),
    .req1     (req1),
    .din1     (din1),
    .ack0     (ack0),
    .ack1     (ack1),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         req0;
    logic [W-1:0] din0;
    logic         req1;
    logic [W-1:0] din1;
    logic         ack0;
    logic         ack1;
    logic [W-1:0] dout;
    logic         vld;
    logic         busy;
    logic         owner;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  bit   both_seen = 1'b0;

  always @(negedge clk) if (ack0 && ack1) both_seen = 1'b1;

  task automatic add(input logic r, input logic q0, input logic [W-1:0] d0,
                     input logic q1, input logic [W-1:0] d1,
                     input logic a0, input logic a1, input logic [W-1:0] o,
                     input logic v, input logic b, input logic ow);
    vec_t t;
    t.rst = r; t.req0 = q0; t.din0 = d0; t.req1 = q1; t.din1 = d1;
    t.ack0 = a0; t.ack1 = a1; t.dout = o; t.vld = v; t.busy = b; t.owner = ow;
    vecs.push_back(t);
  endtask

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;

    //   rst q0 din0    q1 din1    | a0 a1 dout    vld busy own
    // reset with req0 held, then single request 101 -> 111
    add(0, 1, 3'b101, 0, 3'b000,   0, 0, 3'b000, 0, 0, 1);
    add(0, 1, 3'b101, 0, 3'b000,   0, 0, 3'b000, 0, 0, 1);
    add(1, 1, 3'b101, 0, 3'b000,   0, 0, 3'b000, 0, 1, 0);
    add(1, 1, 3'b101, 0, 3'b000,   1, 0, 3'b111, 1, 1, 0);
    add(1, 1, 3'b101, 0, 3'b000,   1, 0, 3'b111, 1, 1, 0);
    add(1, 0, 3'b101, 0, 3'b000,   0, 0, 3'b111, 0, 0, 0);
    add(1, 0, 3'b101, 0, 3'b000,   0, 0, 3'b111, 0, 0, 0);
    // simultaneous from reset: 0 wins (110 -> 101), then 1 (011 -> 010)
    add(0, 1, 3'b110, 1, 3'b011,   0, 0, 3'b000, 0, 0, 1);
    add(1, 1, 3'b110, 1, 3'b011,   0, 0, 3'b000, 0, 1, 0);
    add(1, 1, 3'b110, 1, 3'b011,   1, 0, 3'b101, 1, 1, 0);
    add(1, 0, 3'b110, 1, 3'b011,   0, 0, 3'b101, 0, 0, 0);
    add(1, 0, 3'b110, 1, 3'b011,   0, 0, 3'b101, 0, 1, 1);
    add(1, 0, 3'b110, 1, 3'b011,   0, 1, 3'b010, 1, 1, 1);
    add(1, 0, 3'b110, 0, 3'b011,   0, 0, 3'b010, 0, 0, 1);
    // abort in CONV, then retry 100 -> 110
    add(1, 0, 3'b000, 1, 3'b100,   0, 0, 3'b010, 0, 1, 1);
    add(1, 0, 3'b000, 0, 3'b100,   0, 0, 3'b010, 0, 0, 1);
    add(1, 0, 3'b000, 1, 3'b100,   0, 0, 3'b010, 0, 1, 1);
    add(1, 0, 3'b000, 1, 3'b100,   0, 1, 3'b110, 1, 1, 1);
    add(1, 0, 3'b000, 0, 3'b100,   0, 0, 3'b110, 0, 0, 1);
    // operand stability: 111 -> 100 while din0 moves to 000
    add(1, 1, 3'b111, 0, 3'b000,   0, 0, 3'b110, 0, 1, 0);
    add(1, 1, 3'b111, 0, 3'b000,   1, 0, 3'b100, 1, 1, 0);
    add(1, 1, 3'b000, 0, 3'b000,   1, 0, 3'b100, 1, 1, 0);
    add(1, 1, 3'b000, 0, 3'b000,   1, 0, 3'b100, 1, 1, 0);
    add(1, 0, 3'b000, 0, 3'b000,   0, 0, 3'b100, 0, 0, 0);
    // reset mid-HOLD, request re-sampled after release (010 -> 011)
    add(1, 1, 3'b010, 0, 3'b000,   0, 0, 3'b100, 0, 1, 0);
    add(1, 1, 3'b010, 0, 3'b000,   1, 0, 3'b011, 1, 1, 0);
    add(0, 1, 3'b010, 0, 3'b000,   0, 0, 3'b000, 0, 0, 1);
    add(1, 1, 3'b010, 0, 3'b000,   0, 0, 3'b000, 0, 1, 0);
    add(1, 1, 3'b010, 0, 3'b000,   1, 0, 3'b011, 1, 1, 0);
    add(1, 0, 3'b010, 0, 3'b000,   0, 0, 3'b011, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; req0 = vecs[i].req0; din0 = vecs[i].din0;
      req1 = vecs[i].req1; din1 = vecs[i].din1;
      @(posedge clk); #1;
      tests++;
      if ({ack0, ack1, dout, dout_vld, busy, owner} !==
          {vecs[i].ack0, vecs[i].ack1, vecs[i].dout, vecs[i].vld, vecs[i].busy, vecs[i].owner}) begin
        fails++;
        $display("FAIL vec%0d: got ack0=%b ack1=%b dout=%b vld=%b busy=%b owner=%b, want ack0=%b ack1=%b dout=%b vld=%b busy=%b owner=%b",
                 i, ack0, ack1, dout, dout_vld, busy, owner,
                 vecs[i].ack0, vecs[i].ack1, vecs[i].dout, vecs[i].vld, vecs[i].busy, vecs[i].owner);
      end
    end

    // Round-robin: both requesters keep re-asserting. The owner drops its
    // request for one cycle after each ack. Expected grants are 0,1,0,1,0,1.
    // Operand 001 gives Gray 001; operand 110 gives Gray 101.
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; din0 = 3'b001; din1 = 3'b110;
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 6; t++) begin
      logic         exp_idx;
      logic [W-1:0] exp_dout;
      int           c;
      exp_idx  = (t % 2 == 1);
      exp_dout = exp_idx ? 3'b101 : 3'b001;
      c = 0;
      while (!(ack0 || ack1) && c < 10) begin
        @(negedge clk);
        c++;
      end
      tests++;
      if (!(ack0 || ack1)) begin
        fails++;
        $display("FAIL rr%0d: no ack within 10 cycles, want ack%0d", t, exp_idx);
        break;
      end
      if (ack1 !== exp_idx) begin
        fails++;
        $display("FAIL rr%0d grant: got ack0=%b ack1=%b, want ack%0d", t, ack0, ack1, exp_idx);
      end
      tests++;
      if (dout !== exp_dout) begin
        fails++;
        $display("FAIL rr%0d dout: got %b, want %b", t, dout, exp_dout);
      end
      if (exp_idx) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clk);
      if (exp_idx) req1 = 1'b1; else req0 = 1'b1;
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    tests++;
    if (both_seen) begin
      fails++;
      $display("FAIL ack_mutex: got ack0 and ack1 high together, want never both high");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got simulation time limit, want bench to finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
